// File: rtl/lif_neuron_core_if.sv
// Bundles the per-timestep input and output signals of the LIF soma stage.
// The master drives synaptic sums and configuration; the slave is the neuron core.
interface lif_neuron_core_if #(
  parameter int N_STAGE = 6,
  parameter int MEM_W   = 12,
  parameter int REF_W   = 4,
  parameter int CNT_W   = 16
);
  logic                      in_valid;
  logic signed [N_STAGE+1:0] y_in;
  logic        [MEM_W-2:0]   threshold;
  logic        [3:0]         leak_shift;
  logic        [REF_W-1:0]   refrac_len;
  logic                      cnt_clear;
  logic                      spike;
  logic signed [MEM_W-1:0]   mem_out;
  logic                      out_valid;
  logic                      refractory;
  logic        [CNT_W-1:0]   spike_count;

  modport master (
    output in_valid, y_in, threshold, leak_shift, refrac_len, cnt_clear,
    input  spike, mem_out, out_valid, refractory, spike_count
  );

  modport slave (
    input  in_valid, y_in, threshold, leak_shift, refrac_len, cnt_clear,
    output spike, mem_out, out_valid, refractory, spike_count
  );
endinterface

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire soma: shift leak, saturating integration, threshold
// spike with programmable refractory period and a saturating spike counter.
module lif_neuron_core #(
  parameter int N_STAGE = 6,
  parameter int MEM_W   = 12,
  parameter int REF_W   = 4,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  lif_neuron_core_if.slave  bus
);
  localparam int Y_W = N_STAGE + 2;
  localparam logic [REF_W-1:0] REF_ONE = {{(REF_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INTEG   = 1'b0,
    ST_REFRACT = 1'b1
  } state_t;

  state_t                  state_q;
  logic signed [MEM_W-1:0] mem_q;
  logic signed [MEM_W-1:0] mem_d;
  logic        [REF_W-1:0] ref_q;
  logic                    spike_q;
  logic                    valid_q;
  logic                    refr_q;
  logic        [CNT_W-1:0] cnt_q;
  logic        [CNT_W-1:0] cnt_d;

  logic signed [MEM_W-1:0] shifted_s;
  logic signed [MEM_W-1:0] leaked_s;
  logic signed [MEM_W:0]   sum_s;
  logic                    fire_s;
  logic                    spike_now_s;

  // Clamp a one-bit-wider sum into the membrane range instead of wrapping.
  function automatic logic signed [MEM_W-1:0] clamp_mem(input logic signed [MEM_W:0] x);
    logic signed [MEM_W:0] hi;
    logic signed [MEM_W:0] lo;
    hi = {2'b00, {(MEM_W-1){1'b1}}};
    lo = {2'b11, {(MEM_W-1){1'b0}}};
    if (x > hi) begin
      return hi[MEM_W-1:0];
    end else if (x < lo) begin
      return lo[MEM_W-1:0];
    end else begin
      return x[MEM_W-1:0];
    end
  endfunction

  // Leak, integrate, saturate and compare against the threshold.
  always_comb begin
    shifted_s = mem_q >>> bus.leak_shift;
    if (bus.leak_shift == 4'd0) begin
      leaked_s = mem_q;
    end else begin
      leaked_s = mem_q - shifted_s;
    end
    sum_s  = $signed({leaked_s[MEM_W-1], leaked_s})
           + $signed({{(MEM_W+1-Y_W){bus.y_in[Y_W-1]}}, bus.y_in});
    mem_d  = clamp_mem(sum_s);
    fire_s = $signed({mem_d[MEM_W-1], mem_d}) >= $signed({2'b00, bus.threshold});
    spike_now_s = bus.in_valid && (state_q == ST_INTEG) && fire_s;
  end

  // Spike counter next state; clear takes priority over an increment.
  always_comb begin
    if (bus.cnt_clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (spike_now_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Integrate/refractory state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INTEG;
      mem_q   <= {MEM_W{1'b0}};
      ref_q   <= {REF_W{1'b0}};
      spike_q <= 1'b0;
      valid_q <= 1'b0;
      refr_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= bus.in_valid;
      cnt_q   <= cnt_d;
      if (bus.in_valid) begin
        case (state_q)
          ST_INTEG: begin
            if (fire_s) begin
              spike_q <= 1'b1;
              mem_q   <= {MEM_W{1'b0}};
              if (bus.refrac_len != {REF_W{1'b0}}) begin
                state_q <= ST_REFRACT;
                ref_q   <= bus.refrac_len;
                refr_q  <= 1'b1;
              end else begin
                state_q <= ST_INTEG;
                refr_q  <= 1'b0;
              end
            end else begin
              spike_q <= 1'b0;
              mem_q   <= mem_d;
            end
          end
          ST_REFRACT: begin
            // Synaptic input is discarded; leave after exactly refrac_len timesteps.
            spike_q <= 1'b0;
            mem_q   <= {MEM_W{1'b0}};
            if (ref_q <= REF_ONE) begin
              state_q <= ST_INTEG;
              ref_q   <= {REF_W{1'b0}};
              refr_q  <= 1'b0;
            end else begin
              ref_q   <= ref_q - REF_ONE;
              refr_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_INTEG;
            spike_q <= 1'b0;
            mem_q   <= {MEM_W{1'b0}};
            ref_q   <= {REF_W{1'b0}};
            refr_q  <= 1'b0;
          end
        endcase
      end else begin
        spike_q <= 1'b0;
      end
    end
  end

  assign bus.spike       = spike_q;
  assign bus.mem_out     = mem_q;
  assign bus.out_valid   = valid_q;
  assign bus.refractory  = refr_q;
  assign bus.spike_count = cnt_q;
endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed plus randomized bench for lif_neuron_core, checked against an
// integer-arithmetic neuron model that tracks remaining refractory timesteps.
module tb_lif_neuron_core;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lif_neuron_core_if #(.N_STAGE(6), .MEM_W(12), .REF_W(4), .CNT_W(16)) bus ();

  lif_neuron_core #(.N_STAGE(6), .MEM_W(12), .REF_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_v;
  int m_ref_left;
  int m_cnt;
  int e_spike;
  int e_ov;

  function automatic void model_reset();
    m_v = 0; m_ref_left = 0; m_cnt = 0; e_spike = 0; e_ov = 0;
  endfunction

  function automatic void model_step(input bit v, input int y, input int thr,
                                     input int ls, input int rl, input bit clr);
    int leaked;
    int sum;
    e_spike = 0;
    e_ov    = v ? 1 : 0;
    if (v) begin
      if (m_ref_left > 0) begin
        m_ref_left = m_ref_left - 1;
        m_v = 0;
      end else begin
        leaked = (ls == 0) ? m_v : m_v - (m_v >>> ls);
        sum = leaked + y;
        if (sum > 2047) sum = 2047;
        if (sum < -2048) sum = -2048;
        if (sum >= thr) begin
          e_spike = 1;
          m_v = 0;
          m_ref_left = rl;
        end else begin
          m_v = sum;
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (e_spike == 1 && m_cnt < 65535) m_cnt = m_cnt + 1;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".spike"},      {31'd0, bus.spike},       e_spike);
    check({tag, ".mem"},        $signed(bus.mem_out),     m_v);
    check({tag, ".out_valid"},  {31'd0, bus.out_valid},   e_ov);
    check({tag, ".refractory"}, {31'd0, bus.refractory},  (m_ref_left > 0) ? 1 : 0);
    check({tag, ".count"},      {16'd0, bus.spike_count}, m_cnt);
  endtask

  task automatic step(input string tag, input bit v, input int y, input int thr,
                      input int ls, input int rl, input bit clr, input bit do_check);
    bus.in_valid   = v;
    bus.y_in       = y[7:0];
    bus.threshold  = thr[10:0];
    bus.leak_shift = ls[3:0];
    bus.refrac_len = rl[3:0];
    bus.cnt_clear  = clr;
    model_step(v, y, thr, ls, rl, clr);
    @(posedge clk);
    #1;
    if (do_check) check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.cnt_clear = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    check_all(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.y_in = 8'sd0; bus.threshold = 11'd100;
    bus.leak_shift = 4'd0; bus.refrac_len = 4'd0; bus.cnt_clear = 1'b0;
    @(posedge clk);
    do_reset("reset");

    // Plain integration to a spike
    for (int i = 0; i < 3; i++) step("t1", 1'b1, 40, 100, 0, 0, 1'b0, 1'b1);
    check("t1.mem_const", $signed(bus.mem_out), 0);
    check("t1.spike_const", {31'd0, bus.spike}, 1);
    check("t1.cnt_const", {16'd0, bus.spike_count}, 1);

    // Shift leak
    step("t2", 1'b1, 64, 100, 2, 0, 1'b0, 1'b1);
    step("t2", 1'b1, 0,  100, 2, 0, 1'b0, 1'b1);
    step("t2", 1'b1, 0,  100, 2, 0, 1'b0, 1'b1);
    check("t2.mem_const", $signed(bus.mem_out), 36);

    // Negative saturation
    for (int i = 0; i < 40; i++) step("t3", 1'b1, -64, 2047, 0, 0, 1'b0, 1'b1);
    check("t3.mem_const", $signed(bus.mem_out), -2048);

    // Refractory window
    do_reset("t4.reset");
    for (int i = 0; i < 4; i++) step("t4", 1'b1, 64, 100, 0, 2, 1'b0, 1'b1);
    step("t4.post", 1'b1, 64, 100, 0, 2, 1'b0, 1'b1);
    check("t4.mem_const", $signed(bus.mem_out), 64);

    // Reset while refractory
    do_reset("t5.reset0");
    for (int i = 0; i < 4; i++) step("t5.fill", 1'b1, 64, 1, 0, 0, 1'b0, 1'b1);
    step("t5.ref", 1'b1, 64, 1, 0, 3, 1'b0, 1'b1);
    do_reset("t5.reset");
    step("t5.after", 1'b1, 10, 100, 0, 0, 1'b0, 1'b1);
    check("t5.mem_const", $signed(bus.mem_out), 10);

    // Idle gaps hold state and drop pulses
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 5; i++) step("t6.gap", 1'b0, 64, 100, 0, 0, 1'b0, 1'b1);
      step("t6.sample", 1'b1, 20, 100, 1, 0, 1'b0, 1'b1);
    end

    // Counter saturation and clear priority
    do_reset("t6.reset");
    for (int i = 0; i < 65535; i++) step("t6.fill", 1'b1, 64, 1, 0, 0, 1'b0, 1'b0);
    check("t6.cnt_full", {16'd0, bus.spike_count}, 65535);
    step("t6.sat", 1'b1, 64, 1, 0, 0, 1'b0, 1'b1);
    check("t6.sat_const", {16'd0, bus.spike_count}, 65535);
    step("t6.clr", 1'b1, 64, 1, 0, 0, 1'b1, 1'b1);
    check("t6.clr_const", {16'd0, bus.spike_count}, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(3) != 0), $urandom_range(128) - 64,
           $urandom_range(300) + 1, $urandom_range(15), $urandom_range(15),
           ($urandom_range(40) == 0), 1'b1);
    end
    for (int i = 0; i < 200; i++) begin
      step("rand_hi", 1'b1, $urandom_range(128) - 64, $urandom_range(2046) + 1,
           $urandom_range(3), $urandom_range(2), 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
